clk_en_gen: RTL

//  Multi-channel, run-time programmable clock/clock-enable generator on a single reference clock.

---
 rtl/clk_en_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel programmable clock / clock-enable generator running entirely on refclk.
// Config writes take effect one cycle later; a write while running forces all channels to realign.
module clk_en_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEF_DIV     = 5,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outce,
    output logic              locked
);
    localparam int               LK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_SETTLE, S_LOCKED} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div     [NUM_CH];
    logic [DIV_W-1:0] r_high    [NUM_CH];
    logic [DIV_W-1:0] r_phase   [NUM_CH];
    logic [DIV_W-1:0] r_cnt     [NUM_CH];
    logic [DIV_W-1:0] w_cnt_nxt [NUM_CH];
    logic [LK_W-1:0]  r_lock_cnt;
    logic             r_cfg_err;
    logic             r_locked;
    logic [NUM_CH-1:0] r_outclk;
    logic [NUM_CH-1:0] r_outce;

    logic             w_ch_ok;
    logic             w_div_fix;
    logic             w_high_fix;
    logic             w_phase_fix;
    logic             w_resync;
    logic [DIV_W-1:0] w_div_s;
    logic [DIV_W-1:0] w_high_s;
    logic [DIV_W-1:0] w_phase_s;

    assign cfg_err = r_cfg_err;
    assign outclk  = r_outclk;
    assign outce   = r_outce;
    assign locked  = r_locked;

    // Coercion chain: high and phase are judged against the already-coerced period.
    always_comb begin
        w_ch_ok     = (int'(cfg_ch) < NUM_CH);
        w_div_fix   = (cfg_div < DIV_W'(2));
        w_div_s     = w_div_fix ? DIV_W'(2) : cfg_div;
        w_high_fix  = (cfg_high == '0) || (cfg_high >= w_div_s);
        w_high_s    = w_high_fix ? (w_div_s >> 1) : cfg_high;
        w_phase_fix = (cfg_phase >= w_div_s);
        w_phase_s   = w_phase_fix ? '0 : cfg_phase;
        w_resync    = cfg_wr && w_ch_ok && ((r_state == S_SETTLE) || (r_state == S_LOCKED));
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] >= r_div[i] - DIV_W'(1)) ? '0 : r_cnt[i] + DIV_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (run) w_state_nxt = S_ALIGN;
            S_ALIGN:  w_state_nxt = run ? S_SETTLE : S_IDLE;
            S_SETTLE: begin
                if (!run)                        w_state_nxt = S_IDLE;
                else if (w_resync)               w_state_nxt = S_ALIGN;
                else if (r_lock_cnt == LK_LAST)  w_state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                if (!run)          w_state_nxt = S_IDLE;
                else if (w_resync) w_state_nxt = S_ALIGN;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_cfg_err  <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_outclk   <= '0;
            r_outce    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]   <= DIV_RST;
                r_high[i]  <= DIV_RST >> 1;
                r_phase[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_cfg_err  <= cfg_wr && (!w_ch_ok || w_div_fix || w_high_fix || w_phase_fix);
            r_locked   <= (w_state_nxt == S_LOCKED);
            r_lock_cnt <= (r_state == S_SETTLE) ? r_lock_cnt + LK_W'(1) : '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_wr && w_ch_ok && (cfg_ch == CH_W'(i))) begin
                    r_div[i]   <= w_div_s;
                    r_high[i]  <= w_high_s;
                    r_phase[i] <= w_phase_s;
                end
                if (!run || (r_state == S_IDLE)) begin
                    r_cnt[i]    <= '0;
                    r_outclk[i] <= 1'b0;
                    r_outce[i]  <= 1'b0;
                end else if (r_state == S_ALIGN) begin
                    r_cnt[i]    <= r_phase[i];
                    r_outclk[i] <= (r_phase[i] < r_high[i]);
                    r_outce[i]  <= (r_phase[i] == '0);
                end else begin
                    r_cnt[i]    <= w_cnt_nxt[i];
                    r_outclk[i] <= (w_cnt_nxt[i] < r_high[i]);
                    r_outce[i]  <= (w_cnt_nxt[i] == '0);
                end
            end
        end
    end
endmodule
